// File: rtl/timer_status_reg.sv
// Timer status register (TSR) with the watchdog state machine and reset-request stretcher.
// Build option: define TIM_WDOG_RESET_EN to enable the watchdog reset stage (WRS load + 16-cycle request).
module timer_status_reg (
    input  logic       CB,
    input  logic       resetCore,
    input  logic       wdEvent,
    input  logic       pitEvent,
    input  logic       fitEvent,
    input  logic [0:9] timerControlL2,
    input  logic       sprWrite,
    input  logic       timerRstStatDcd,
    input  logic [0:5] sprDataIn,
    output logic [0:5] timerStatusOutL2,
    output logic [0:1] TIM_wdResetReq
);

    // TSR bit positions
    localparam int ENW = 0;
    localparam int WIS = 1;
    localparam int PIS = 4;
    localparam int FIS = 5;

    logic [0:5] tsr_q;
    logic [0:5] tsr_d;
    logic [0:5] clr_mask;
    logic [0:5] set_mask;
    logic [0:1] wrc;

    assign wrc = timerControlL2[2:3];

`ifdef TIM_WDOG_RESET_EN
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_STRETCH = 1'b1
    } stretch_state_t;

    stretch_state_t st_q;
    stretch_state_t st_d;
    logic [3:0]     cnt_q;
    logic [3:0]     cnt_d;
    logic [0:1]     req_q;
    logic [0:1]     req_d;
    logic           stretch_start;
    logic           unused_tcr;

    assign unused_tcr = ^{timerControlL2[0:1], timerControlL2[4:9]};
`else
    logic unused_tcr;

    assign unused_tcr = ^{timerControlL2, wrc};
`endif

    always_comb begin
        clr_mask = (sprWrite && timerRstStatDcd) ? sprDataIn : 6'b000000;
        set_mask = 6'b000000;
        set_mask[PIS] = pitEvent;
        set_mask[FIS] = fitEvent;
`ifdef TIM_WDOG_RESET_EN
        stretch_start = 1'b0;
`endif
        if (wdEvent) begin
            case ({tsr_q[ENW], tsr_q[WIS]})
                2'b00:   set_mask[ENW] = 1'b1;
                2'b01:   set_mask[ENW] = 1'b1;
                2'b10:   set_mask[WIS] = 1'b1;
                default: begin
`ifdef TIM_WDOG_RESET_EN
                    // A running stretch blocks a new one even if software already cleared WRS.
                    if ((wrc != 2'b00) && (tsr_q[2:3] == 2'b00) && (st_q == ST_IDLE)) begin
                        set_mask[2:3] = wrc;
                        stretch_start = 1'b1;
                    end
`endif
                end
            endcase
        end
        // Set is applied after the clear so a same-cycle event wins over software.
        tsr_d = (tsr_q & ~clr_mask) | set_mask;
`ifndef TIM_WDOG_RESET_EN
        tsr_d[2:3] = 2'b00;
`endif
    end

    always_ff @(posedge CB) begin
        if (resetCore) begin
            tsr_q <= 6'b000000;
        end else begin
            tsr_q <= tsr_d;
        end
    end

    assign timerStatusOutL2 = tsr_q;

`ifdef TIM_WDOG_RESET_EN
    // Request is held from the trigger edge through 15 further edges: 16 visible cycles.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        req_d = req_q;
        case (st_q)
            ST_IDLE: begin
                if (stretch_start) begin
                    st_d  = ST_STRETCH;
                    cnt_d = 4'd0;
                    req_d = wrc;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == 4'd15) begin
                    st_d  = ST_IDLE;
                    cnt_d = 4'd0;
                    req_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = 4'd0;
                req_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CB) begin
        if (resetCore) begin
            st_q  <= ST_IDLE;
            cnt_q <= 4'd0;
            req_q <= 2'b00;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign TIM_wdResetReq = req_q;
`else
    assign TIM_wdResetReq = 2'b00;
`endif

endmodule
